// File: rtl/adc_clark_seq.sv
// -----------------------------------------------------------------------------
// adc_clark_seq
//
// Sequences three-phase ADC samples into a Clark transform stage:
//   * On i_calib, averages 2^CALIB_LOG2 samples per channel to learn the
//     per-phase zero-current offsets.
//   * Once calibrated, each accepted ADC sample is offset-corrected,
//     sign-extended to 16 bits and presented to the transform with a
//     one-cycle o_en strobe.
//   * While the transform is busy, further samples are dropped (o_drop).
//   * If the transform never answers within TIMEOUT cycles, the sticky
//     o_err flag is raised and the sequencer returns to READY.
//
// Parameters
//   CALIB_LOG2 : log2 of samples averaged per calibration (1..8)
//   TIMEOUT    : max cycles spent in BUSY waiting for i_tr_en (4..255)
//
// Ports
//   clk, rstn          : clock, asynchronous active-low reset
//   i_calib            : pulse, start/restart calibration
//   i_adc_en           : strobe, i_adc_a/b/c valid
//   i_adc_a/b/c [11:0] : unsigned raw ADC codes
//   i_tr_en            : transform done strobe
//   o_en               : strobe to the transform input
//   o_ia/o_ib/o_ic     : signed 16-bit offset-removed currents
//   o_calib_done       : valid offsets held (READY or BUSY)
//   o_drop             : pulse, an ADC sample was discarded
//   o_err              : sticky transform timeout flag
//   o_sum_err          : (only with ADC_CLARK_SEQ_SUMCHK_EN) pulses with
//                        o_en when |o_ia+o_ib+o_ic| > 255
//
// Optional feature macro: ADC_CLARK_SEQ_SUMCHK_EN
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module adc_clark_seq #(
  parameter int CALIB_LOG2 = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_calib,
  input  logic        i_adc_en,
  input  logic [11:0] i_adc_a,
  input  logic [11:0] i_adc_b,
  input  logic [11:0] i_adc_c,
  input  logic        i_tr_en,
  output logic        o_en,
  output logic [15:0] o_ia,
  output logic [15:0] o_ib,
  output logic [15:0] o_ic,
  output logic        o_calib_done,
  output logic        o_drop,
  output logic        o_err
`ifdef ADC_CLARK_SEQ_SUMCHK_EN
  ,
  output logic        o_sum_err
`endif
);

  localparam int AW = 12 + CALIB_LOG2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CALIB = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;
  localparam logic [1:0] ST_BUSY  = 2'd3;

  // Counter value seen during the last allowed BUSY cycle; the counter would
  // reach TIMEOUT on the following edge.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]            state_q, state_d;
  logic [AW-1:0]         acc_a_q, acc_a_d;
  logic [AW-1:0]         acc_b_q, acc_b_d;
  logic [AW-1:0]         acc_c_q, acc_c_d;
  logic [CALIB_LOG2-1:0] cnt_q, cnt_d;
  logic [11:0]           off_a_q, off_a_d;
  logic [11:0]           off_b_q, off_b_d;
  logic [11:0]           off_c_q, off_c_d;
  logic [7:0]            tmo_q, tmo_d;
  logic                  en_q, en_d;
  logic                  drop_q, drop_d;
  logic                  err_q, err_d;
  logic                  cdone_q, cdone_d;
  logic [15:0]           ia_q, ia_d;
  logic [15:0]           ib_q, ib_d;
  logic [15:0]           ic_q, ic_d;

  logic [AW-1:0]         sum_a_s, sum_b_s, sum_c_s;

  // Accumulator values including the current sample.
  assign sum_a_s = acc_a_q + AW'(i_adc_a);
  assign sum_b_s = acc_b_q + AW'(i_adc_b);
  assign sum_c_s = acc_c_q + AW'(i_adc_c);

  // Next-state and datapath logic for the sequencer.
  always_comb begin
    state_d = state_q;
    acc_a_d = acc_a_q;
    acc_b_d = acc_b_q;
    acc_c_d = acc_c_q;
    cnt_d   = cnt_q;
    off_a_d = off_a_q;
    off_b_d = off_b_q;
    off_c_d = off_c_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    en_d    = 1'b0;
    drop_d  = 1'b0;
    ia_d    = ia_q;
    ib_d    = ib_q;
    ic_d    = ic_q;

    if (i_calib) begin
      // Calibration request overrides everything, including a same-cycle
      // ADC sample, which is silently ignored (no drop pulse).
      state_d = ST_CALIB;
      acc_a_d = '0;
      acc_b_d = '0;
      acc_c_d = '0;
      cnt_d   = '0;
      tmo_d   = 8'd0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_CALIB: begin
          if (i_adc_en) begin
            if (&cnt_q) begin
              off_a_d = sum_a_s[AW-1:CALIB_LOG2];
              off_b_d = sum_b_s[AW-1:CALIB_LOG2];
              off_c_d = sum_c_s[AW-1:CALIB_LOG2];
              cnt_d   = '0;
              state_d = ST_READY;
            end else begin
              acc_a_d = sum_a_s;
              acc_b_d = sum_b_s;
              acc_c_d = sum_c_s;
              cnt_d   = cnt_q + 1'b1;
            end
          end else begin
            state_d = ST_CALIB;
          end
        end
        ST_READY: begin
          if (i_adc_en) begin
            // 16-bit two's-complement difference of zero-extended codes is
            // the sign-extended result in -4095..4095.
            en_d    = 1'b1;
            ia_d    = {4'd0, i_adc_a} - {4'd0, off_a_q};
            ib_d    = {4'd0, i_adc_b} - {4'd0, off_b_q};
            ic_d    = {4'd0, i_adc_c} - {4'd0, off_c_q};
            tmo_d   = 8'd0;
            state_d = ST_BUSY;
          end else begin
            state_d = ST_READY;
          end
        end
        ST_BUSY: begin
          if (i_adc_en) begin
            drop_d = 1'b1;
          end else begin
            drop_d = 1'b0;
          end
          // Done strobe has priority over a coincident timeout.
          if (i_tr_en) begin
            state_d = ST_READY;
          end else if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = ST_READY;
          end else begin
            tmo_d = tmo_q + 8'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    cdone_d = (state_d == ST_READY) || (state_d == ST_BUSY);
  end

`ifdef ADC_CLARK_SEQ_SUMCHK_EN
  logic signed [17:0] phase_sum_s;
  logic               sum_err_q, sum_err_d;

  // Kirchhoff sanity check on the currents about to be issued.
  always_comb begin
    phase_sum_s = $signed({{2{ia_d[15]}}, ia_d}) + $signed({{2{ib_d[15]}}, ib_d})
                + $signed({{2{ic_d[15]}}, ic_d});
    if (en_d && ((phase_sum_s > 18'sd255) || (phase_sum_s < -18'sd255))) begin
      sum_err_d = 1'b1;
    end else begin
      sum_err_d = 1'b0;
    end
  end

  // Sum-check flag register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sum_err_q <= 1'b0;
    end else begin
      sum_err_q <= sum_err_d;
    end
  end

  assign o_sum_err = sum_err_q;
`endif

  // Sequencer state and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      acc_a_q <= '0;
      acc_b_q <= '0;
      acc_c_q <= '0;
      cnt_q   <= '0;
      off_a_q <= 12'd0;
      off_b_q <= 12'd0;
      off_c_q <= 12'd0;
      tmo_q   <= 8'd0;
      en_q    <= 1'b0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
      cdone_q <= 1'b0;
      ia_q    <= 16'd0;
      ib_q    <= 16'd0;
      ic_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      acc_a_q <= acc_a_d;
      acc_b_q <= acc_b_d;
      acc_c_q <= acc_c_d;
      cnt_q   <= cnt_d;
      off_a_q <= off_a_d;
      off_b_q <= off_b_d;
      off_c_q <= off_c_d;
      tmo_q   <= tmo_d;
      en_q    <= en_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
      cdone_q <= cdone_d;
      ia_q    <= ia_d;
      ib_q    <= ib_d;
      ic_q    <= ic_d;
    end
  end

  assign o_en         = en_q;
  assign o_drop       = drop_q;
  assign o_err        = err_q;
  assign o_calib_done = cdone_q;
  assign o_ia         = ia_q;
  assign o_ib         = ib_q;
  assign o_ic         = ic_q;

endmodule

// File: doc/adc_clark_seq.md
ADC_CLARK_SEQ -- requirements
Module: adc_clark_seq

Interface
REQ-001 Parameter CALIB_LOG2, default 4, meaning log2 of the number of ADC samples averaged per offset calibration (range 1..8).
REQ-002 Parameter TIMEOUT, default 15, meaning maximum cycles in BUSY waiting for the transform done strobe (range 4..255).
REQ-003 rstn  input  1  reset; one clock domain; reset is asynchronous and active-low.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 i_calib  input  1  one-cycle pulse that starts or restarts offset calibration.
REQ-006 i_adc_en  input  1  one-cycle strobe; i_adc_a/b/c valid this cycle.
REQ-007 i_adc_a, i_adc_b, i_adc_c  input  12 each  unsigned raw phase-current ADC codes.
REQ-008 o_en  output  1  one-cycle strobe to the Clark transform input enable.
REQ-009 o_ia, o_ib, o_ic  output  16 each  signed offset-removed phase currents to the transform.
REQ-010 i_tr_en  input  1  done strobe from the Clark transform output enable.
REQ-011 o_calib_done  output  1  high while valid offsets are held (READY or BUSY).
REQ-012 o_drop  output  1  one-cycle pulse when an ADC sample is discarded.
REQ-013 o_err  output  1  sticky timeout flag.

Function
REQ-014 FSM states: IDLE, CALIB, READY, BUSY; reset state IDLE.
REQ-015 IDLE: ignore i_adc_en (no o_drop); on i_calib go to CALIB.
REQ-016 Entry to CALIB: clear three accumulators (12+CALIB_LOG2 bits each, unsigned) and the sample counter.
REQ-017 CALIB: each i_adc_en adds each channel code to its accumulator and increments the counter; no o_en.
REQ-018 When the 2^CALIB_LOG2-th sample is accumulated: offset_x <= (accumulator incl. that sample) >> CALIB_LOG2 (truncating), counter cleared, next state READY.
REQ-019 READY: on i_adc_en, next cycle o_en=1 and o_ix = sign-extended (i_adc_x - offset_x) for x=a,b,c (range -4095..4095); state to BUSY.
REQ-020 o_ia/o_ib/o_ic hold their value until the next issued sample; o_en high for exactly one cycle per issue.
REQ-021 BUSY: timeout counter cleared on entry, incremented each cycle; on i_tr_en go to READY.
REQ-022 BUSY: if the counter reaches TIMEOUT without i_tr_en, set o_err and go to READY.
REQ-023 i_tr_en and timeout in the same cycle: i_tr_en wins; o_err unchanged.
REQ-024 i_adc_en in BUSY: sample discarded, o_drop pulses next cycle; no queueing.
REQ-025 i_tr_en outside BUSY: ignored.
REQ-026 i_calib in any state: go to CALIB next cycle, accumulators cleared; o_calib_done low; o_err cleared; a pending BUSY transaction is abandoned.
REQ-027 i_calib and i_adc_en in the same cycle: the sample is neither issued nor accumulated, and o_drop stays low.
REQ-028 Throughput: at most one sample per 5 cycles with a 3-cycle transform latency; READY->BUSY->READY needs no idle cycle.

Reset
REQ-029 Async assert of rstn: state IDLE; all counters, accumulators and offsets 0; o_en, o_drop, o_err, o_calib_done 0; o_ia/o_ib/o_ic 0.
REQ-030 Reset mid-CALIB or mid-BUSY discards all progress; no o_en is produced after release until a new calibration completes.

Configuration
REQ-031 Macro ADC_CLARK_SEQ_SUMCHK_EN defined: add output o_sum_err (1 bit) that pulses with o_en when |o_ia+o_ib+o_ic| > 255 (18-bit signed sum); reset value 0.
REQ-032 Macro undefined: port o_sum_err and its logic are absent; all other behaviour is identical.

Verification
REQ-033 CALIB_LOG2=2; i_calib; a-codes 2048,2050,2046,2049 -> offset_a=2048, READY after the 4th sample, o_calib_done=1.
REQ-034 Offsets 2048/2048/2048; sample a=2148 b=1998 c=1998 in READY -> next cycle o_en=1, o_ia=100, o_ib=-50, o_ic=-50.
REQ-035 i_tr_en never returned, TIMEOUT=15 -> o_err=1 after 15 BUSY cycles, state READY, next sample issued normally.
REQ-036 i_adc_en two cycles after an issue (BUSY) -> o_drop pulse, no o_en; i_tr_en at cycle 3 -> READY.
REQ-037 rstn low mid-BUSY, then released -> all outputs 0, i_adc_en produces no o_en until recalibrated.
REQ-038 With ADC_CLARK_SEQ_SUMCHK_EN defined: codes a=2348, b=c=2048 at offsets 2048 -> o_ia=300, o_sum_err=1 with o_en.
